// File: rtl/brg_sck_gen.sv
`default_nettype none
// ============================================================================
// Module      : brg_sck_gen
// Description : SPI serial-clock generator. Divides clk by
//               (SPPR+1)*2^(SPR+1), drives SCK with selectable idle polarity
//               and emits one-cycle BaudRate / lead_edge / trail_edge strobes.
//               Runs continuously (cont=1) or as a counted burst of num_bits
//               SCK periods with a busy/done handshake.
//               Optional macro BRG_GUARD_EN adds a guard interval of one
//               half period after the last trailing edge before done/idle.
// Revision    : 1.0 - initial release
// ============================================================================
module brg_sck_gen #(
   parameter int SPR_W     = 3,
   parameter int SPPR_W    = 3,
   parameter int BIT_CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 start,
   input  logic                 cont,
   input  logic [SPPR_W-1:0]    SPPR,
   input  logic [SPR_W-1:0]     SPR,
   input  logic                 CPOL,
   input  logic [BIT_CNT_W-1:0] num_bits,
   output logic                 BaudRate,
   output logic                 SCK,
   output logic                 lead_edge,
   output logic                 trail_edge,
   output logic                 busy,
   output logic                 done
);

   // Half-period counter width: holds H-1 for the largest H without overflow.
   localparam int CNT_W  = SPPR_W + 2**SPR_W - 1;
   // Edge counter must reach 2*num_bits - 1.
   localparam int EDGE_W = BIT_CNT_W + 1;

   localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
   localparam logic [EDGE_W-1:0] c_edge_one = EDGE_W'(1);

`ifdef BRG_GUARD_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_GUARD = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1
   } state_t;
`endif

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;        // cycles elapsed in current half period
   logic [CNT_W-1:0]      r_h_m1;       // latched H-1
   logic [EDGE_W-1:0]     r_edge_cnt;   // SCK edges produced so far
   logic [BIT_CNT_W-1:0]  r_num_bits;   // latched burst length
   logic                  r_cont_mode;  // running in continuous mode
   logic                  r_stop;       // continuous stop requested
   logic                  r_sck;
   logic                  r_baud;
   logic                  r_lead;
   logic                  r_trail;
   logic                  r_busy;
   logic                  r_done;

   logic [CNT_W-1:0]      w_h_m1;
   logic [EDGE_W-1:0]     w_last_idx;
   logic                  w_wrap;
   logic                  w_finish;
   logic                  w_go_cont;
   logic                  w_go_burst;

   // H-1 = (SPPR+1)*2^SPR - 1 = SPPR*2^SPR + (2^SPR - 1); both terms fit
   // in CNT_W bits, so no wider intermediate is needed.
   assign w_h_m1     = (CNT_W'(SPPR) << SPR) + ((c_cnt_one << SPR) - c_cnt_one);

   // Index (0-based) of the final edge of a burst: 2*num_bits - 1.
   assign w_last_idx = {r_num_bits, 1'b0} - c_edge_one;

   // End of the current half period.
   assign w_wrap     = (r_cnt == r_h_m1);

   // The edge being produced now closes the transfer. Only meaningful on a
   // trailing edge: continuous mode stops once cont has been seen low,
   // burst mode stops on edge number 2*num_bits.
   assign w_finish   = r_cont_mode ? (r_stop | ~cont) : (r_edge_cnt == w_last_idx);

   // Launch conditions evaluated in IDLE; continuous mode has priority.
   assign w_go_cont  = cont;
   assign w_go_burst = ~cont & start & (num_bits != '0);

   // Main control FSM with counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_h_m1      <= '0;
         r_edge_cnt  <= '0;
         r_num_bits  <= '0;
         r_cont_mode <= 1'b0;
         r_stop      <= 1'b0;
         r_sck       <= 1'b0;
         r_baud      <= 1'b0;
         r_lead      <= 1'b0;
         r_trail     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         // Strobes are single-cycle: cleared unless re-asserted below.
         r_baud  <= 1'b0;
         r_lead  <= 1'b0;
         r_trail <= 1'b0;
         r_done  <= 1'b0;

         if (clr) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            r_stop     <= 1'b0;
            r_busy     <= 1'b0;
            r_sck      <= CPOL;
         end else if (en) begin
            case (r_state)
               S_IDLE: begin
                  r_cnt      <= '0;
                  r_edge_cnt <= '0;
                  r_stop     <= 1'b0;
                  if (w_go_cont || w_go_burst) begin
                     // Configuration is frozen for the whole transfer.
                     r_h_m1      <= w_h_m1;
                     r_num_bits  <= num_bits;
                     r_cont_mode <= w_go_cont;
                     r_sck       <= CPOL;
                     r_busy      <= 1'b1;
                     r_state     <= S_RUN;
                  end else if (start) begin
                     // Zero-length burst: acknowledge without any edges.
                     r_done <= 1'b1;
                  end
               end

               S_RUN: begin
                  if (r_cont_mode && !cont) begin
                     r_stop <= 1'b1;
                  end
                  if (w_wrap) begin
                     r_cnt      <= '0;
                     r_sck      <= ~r_sck;
                     r_baud     <= 1'b1;
                     r_edge_cnt <= r_edge_cnt + c_edge_one;
                     if (!r_edge_cnt[0]) begin
                        // Edge numbers are 1-based: even index is an odd edge.
                        r_lead <= 1'b1;
                     end else begin
                        r_trail <= 1'b1;
                        if (w_finish) begin
                           r_stop <= 1'b0;
`ifdef BRG_GUARD_EN
                           r_state <= S_GUARD;
`else
                           r_state <= S_IDLE;
                           r_busy  <= 1'b0;
                           r_done  <= ~r_cont_mode;
`endif
                        end
                     end
                  end else begin
                     r_cnt <= r_cnt + c_cnt_one;
                  end
               end

`ifdef BRG_GUARD_EN
               S_GUARD: begin
                  // Hold SCK at idle level for one half period, then release.
                  if (w_wrap) begin
                     r_cnt   <= '0;
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= ~r_cont_mode;
                  end else begin
                     r_cnt <= r_cnt + c_cnt_one;
                  end
               end
`endif

               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // In IDLE the clock follows the live polarity input; it is held low
   // while reset is asserted.
   assign SCK        = (r_state == S_IDLE) ? (CPOL & rst) : r_sck;
   assign BaudRate   = r_baud;
   assign lead_edge  = r_lead;
   assign trail_edge = r_trail;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_brg_sck_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_brg_sck_gen
// Description : Self-checking bench for brg_sck_gen. A cycle-level reference
//               model derived from the divisor/edge rules is compared against
//               the DUT every cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brg_sck_gen;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       clr      = 1'b0;
   logic       en       = 1'b0;
   logic       start    = 1'b0;
   logic       cont     = 1'b0;
   logic       CPOL     = 1'b0;
   logic [2:0] SPPR     = 3'd0;
   logic [2:0] SPR      = 3'd0;
   logic [3:0] num_bits = 4'd0;
   logic       BaudRate, SCK, lead_edge, trail_edge, busy, done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   brg_sck_gen #(
      .SPR_W     (3),
      .SPPR_W    (3),
      .BIT_CNT_W (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .en         (en),
      .start      (start),
      .cont       (cont),
      .SPPR       (SPPR),
      .SPR        (SPR),
      .CPOL       (CPOL),
      .num_bits   (num_bits),
      .BaudRate   (BaudRate),
      .SCK        (SCK),
      .lead_edge  (lead_edge),
      .trail_edge (trail_edge),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   // ms: 0 idle, 1 running, 2 guard. Edges happen whenever the number of
   // enabled cycles since busy rose is a multiple of H.
   int ms = 0, elapsed = 0, mh = 1, mn = 0, mk = 0;
   bit mcmode = 0, mstop = 0, mcpol = 0;
   bit e_baud = 0, e_lead = 0, e_trail = 0, e_busy = 0, e_done = 0, e_sck = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ms = 0; elapsed = 0; mstop = 0; mcmode = 0;
         e_baud = 0; e_lead = 0; e_trail = 0; e_busy = 0; e_done = 0; e_sck = 0;
      end else begin
         e_baud = 0; e_lead = 0; e_trail = 0; e_done = 0;
         if (clr) begin
            ms = 0; e_busy = 0; mstop = 0;
         end else if (en) begin
            if (ms == 0) begin
               if (cont || (start && num_bits != 0)) begin
                  ms = 1; mcmode = cont; mcpol = CPOL; mstop = 0; elapsed = 0;
                  mh = (int'(SPPR) + 1) * (1 << SPR);
                  mn = int'(num_bits);
                  e_busy = 1; e_sck = CPOL;
               end else if (start) begin
                  e_done = 1;
               end
            end else if (ms == 1) begin
               if (mcmode && !cont) mstop = 1;
               elapsed++;
               if (elapsed % mh == 0) begin
                  mk = elapsed / mh;
                  e_baud = 1;
                  e_sck = mcpol ^ mk[0];
                  if (mk % 2 == 1) e_lead = 1;
                  else begin
                     e_trail = 1;
                     if (mcmode ? mstop : (mk == 2 * mn)) begin
`ifdef BRG_GUARD_EN
                        ms = 2; elapsed = 0;
`else
                        ms = 0; e_busy = 0; e_done = !mcmode;
`endif
                     end
                  end
               end
            end else begin
               elapsed++;
               if (elapsed == mh) begin
                  ms = 0; e_busy = 0; e_done = !mcmode;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [5:0] a_vec, e_vec;
      a_vec = {BaudRate, SCK, lead_edge, trail_edge, busy, done};
      e_vec = {e_baud, (ms == 0) ? (CPOL & rst) : e_sck, e_lead, e_trail, e_busy, e_done};
      checks++;
      if (a_vec !== e_vec) begin
         errors++;
         $display("FAIL model cyc=%0d {baud,sck,lead,trail,busy,done}: got %b required %b",
                  cyc, a_vec, e_vec);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("idle_reached", int'(busy), 0);
   endtask

   task automatic measure(output int d);
      int c1;
      c1 = -1;
      d  = -1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (BaudRate) begin
            if (c1 < 0) c1 = cyc;
            else begin
               d = cyc - c1;
               break;
            end
         end
      end
   endtask

   int o_first_busy, o_last_busy, o_busy_rise, o_first_edge, o_last_edge;
   int o_edges, o_lead, o_trail, o_dones, o_done_cyc, o_alt_err;

   task automatic observe(input int n);
      bit prev_busy;
      o_first_busy = -1; o_last_busy = -1; o_busy_rise = 0;
      o_first_edge = -1; o_last_edge = -1; o_edges = 0; o_lead = 0; o_trail = 0;
      o_dones = 0; o_done_cyc = -1; o_alt_err = 0;
      prev_busy = busy;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (busy) begin
            if (o_first_busy < 0) o_first_busy = cyc;
            o_last_busy = cyc;
            if (!prev_busy) o_busy_rise++;
         end
         prev_busy = busy;
         if (BaudRate) begin
            o_edges++;
            if (o_first_edge < 0) o_first_edge = cyc;
            o_last_edge = cyc;
            if (lead_edge == trail_edge) o_alt_err++;
            else if (lead_edge != (o_edges % 2 == 1)) o_alt_err++;
         end else if (lead_edge || trail_edge) begin
            o_alt_err++;
         end
         if (lead_edge)  o_lead++;
         if (trail_edge) o_trail++;
         if (done) begin
            o_dones++;
            o_done_cyc = cyc;
         end
      end
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int t, d;
      bit found;
`ifdef BRG_GUARD_EN
      int g;
      g = 1;
`else
      int g;
      g = 0;
`endif

      // Reset / idle polarity
      rst = 1'b0; en = 1'b1;
      tick(3);
      chk("reset_outputs", int'({BaudRate, SCK, lead_edge, trail_edge, busy, done}), 0);
      CPOL = 1'b1; rst = 1'b1;
      tick(2);
      chk("idle_sck_cpol1", int'(SCK), 1);
      chk("idle_busy0", int'(busy), 0);

      // Divisor sweep, continuous mode
      CPOL = 1'b0; SPPR = 3'd0; SPR = 3'd0; cont = 1'b1;
      measure(d);
      chk("period_h1", d, 1);
      tick(1); cont = 1'b0; wait_idle();

      tick(1); SPPR = 3'd2; SPR = 3'd1; cont = 1'b1;
      measure(d);
      chk("period_h6", d, 6);
      tick(1); cont = 1'b0; wait_idle();

      tick(1); SPPR = 3'd7; SPR = 3'd7; cont = 1'b1;
      measure(d);
      chk("period_h1024", d, 1024);
      tick(1); cont = 1'b0; wait_idle();

      // Continuous stop after a lead edge
      tick(1); SPPR = 3'd1; SPR = 3'd0; cont = 1'b1;
      found = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (lead_edge) begin
            found = 1;
            break;
         end
      end
      chk("cont_lead_seen", int'(found), 1);
      tick(1); cont = 1'b0;
      observe(10);
      chk("cont_stop_trail", o_trail, 1);
      chk("cont_stop_lead", o_lead, 0);
      chk("cont_stop_done", o_dones, 0);
      chk("cont_stop_busy", int'(busy), 0);

      // Burst, H=1, 8 bits
      tick(1); SPPR = 3'd0; SPR = 3'd0; CPOL = 1'b0; num_bits = 4'd8; start = 1'b1; t = cyc;
      fork
         observe(25);
         begin tick(1); start = 1'b0; end
      join
      chk("b8_busy_rise", o_first_busy - t, 1);
      chk("b8_first_edge", o_first_edge - t, 2);
      chk("b8_last_edge", o_last_edge - t, 17);
      chk("b8_edges", o_edges, 16);
      chk("b8_leads", o_lead, 8);
      chk("b8_alternate", o_alt_err, 0);
      chk("b8_dones", o_dones, 1);
      chk("b8_done_cyc", o_done_cyc - t, 17 + g);
      chk("b8_last_busy", o_last_busy - t, 16 + g);

      // Burst, H=6, CPOL=1, 2 bits
      tick(1); SPPR = 3'd2; SPR = 3'd1; CPOL = 1'b1; num_bits = 4'd2; start = 1'b1; t = cyc;
      fork
         observe(40);
         begin tick(1); start = 1'b0; end
      join
      chk("b2h6_first_edge", o_first_edge - t, 7);
      chk("b2h6_last_edge", o_last_edge - t, 25);
      chk("b2h6_done_cyc", o_done_cyc - t, 25 + 6 * g);
      chk("b2h6_sck_idle", int'(SCK), 1);

      // Pause for 5 cycles mid-burst, H=2, 3 bits
      tick(1); SPPR = 3'd1; SPR = 3'd0; CPOL = 1'b0; num_bits = 4'd3; start = 1'b1; t = cyc;
      fork
         observe(30);
         begin
            tick(1); start = 1'b0;
            tick(3); en = 1'b0;
            tick(5); en = 1'b1;
         end
      join
      chk("pause_first_edge", o_first_edge - t, 3);
      chk("pause_last_edge", o_last_edge - t, 18);
      chk("pause_edges", o_edges, 6);
      chk("pause_done_cyc", o_done_cyc - t, 18 + 2 * g);

      // Config change and start while busy, H=2, 2 bits
      tick(1); SPPR = 3'd1; SPR = 3'd0; num_bits = 4'd2; start = 1'b1; t = cyc;
      fork
         observe(20);
         begin
            tick(1); start = 1'b0;
            tick(1); SPR = 3'd3; SPPR = 3'd5;
            tick(2); start = 1'b1;
            tick(1); start = 1'b0;
         end
      join
      chk("cfg_last_edge", o_last_edge - t, 9);
      chk("cfg_edges", o_edges, 4);
      chk("cfg_busy_rise", o_busy_rise, 1);
      chk("cfg_dones", o_dones, 1);

      // num_bits = 0
      tick(1); SPPR = 3'd0; SPR = 3'd0; num_bits = 4'd0; start = 1'b1; t = cyc;
      fork
         observe(6);
         begin tick(1); start = 1'b0; end
      join
      chk("nb0_done_cyc", o_done_cyc - t, 1);
      chk("nb0_edges", o_edges, 0);
      chk("nb0_busy", o_busy_rise, 0);

      // clr and start together
      tick(1); num_bits = 4'd4; clr = 1'b1; start = 1'b1; t = cyc;
      fork
         observe(8);
         begin tick(1); clr = 1'b0; start = 1'b0; end
      join
      chk("clrstart_busy", o_busy_rise, 0);
      chk("clrstart_edges", o_edges, 0);
      chk("clrstart_done", o_dones, 0);

      // clr mid-burst
      tick(1); num_bits = 4'd8; start = 1'b1; t = cyc;
      fork
         observe(20);
         begin
            tick(1); start = 1'b0;
            tick(4); clr = 1'b1;
            tick(1); clr = 1'b0;
         end
      join
      chk("clrmid_last_busy", o_last_busy - t, 5);
      chk("clrmid_edges", o_edges, 4);
      chk("clrmid_done", o_dones, 0);

      // Asynchronous reset mid-run
      tick(1); SPPR = 3'd2; SPR = 3'd1; CPOL = 1'b0; cont = 1'b1;
      tick(20);
      #1 rst = 1'b0;
      #1 chk("async_reset_outputs", int'({BaudRate, SCK, lead_edge, trail_edge, busy, done}), 0);
      tick(1); rst = 1'b1; CPOL = 1'b1;
      tick(3); cont = 1'b0;
      wait_idle();
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/brg_sck_gen.md
Name: brg_sck_gen

Overview:
- Parametrised successor to the SPI baud rate generator.
- Divides the system clock by a two-stage prescaler, divisor = (SPPR+1)*2^(SPR+1).
- Drives the SPI serial clock (SCK) with selectable polarity, plus one-cycle leading/trailing edge strobes for the shift/sample logic.
- Runs either continuously or as a counted burst of N bits with busy/done handshake. Sits between the SPI control registers and the shift-register datapath.

Parameters:
- SPR_W, 3, width of SPR exponent select.
- SPPR_W, 3, width of SPPR pre-divider select.
- BIT_CNT_W, 4, width of num_bits burst length.
- localparam CNT_W = SPPR_W + 2**SPR_W - 1, half-period counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear; returns to idle.
- en  in  1  global enable; 0 freezes all counters and outputs.
- start  in  1  burst request pulse; sampled only in IDLE.
- cont  in  1  continuous mode select.
- SPPR  in  SPPR_W  pre-divider, 0..2^SPPR_W-1.
- SPR  in  SPR_W  exponent, 0..2^SPR_W-1.
- CPOL  in  1  SCK idle level.
- num_bits  in  BIT_CNT_W  burst length in SCK periods.
- BaudRate  out  1  one-cycle tick at every SCK edge.
- SCK  out  1  serial clock.
- lead_edge  out  1  tick on first (odd) edge of each period.
- trail_edge  out  1  tick on second (even) edge of each period.
- busy  out  1  high while generating.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters 0; SCK=0; busy, done, BaudRate, lead_edge, trail_edge = 0.
- Half period H = (SPPR+1)*2^SPR system cycles; full SCK period 2H. Counter is CNT_W bits and must not overflow at max values (H=8*128=1024).
- SPPR, SPR, CPOL and num_bits are latched when leaving IDLE. Changes while busy have no effect until the next start.
- In IDLE, SCK = CPOL (live input).
- FSM IDLE -> RUN:
  - Burst: cycle t with en=1, start=1, cont=0, num_bits!=0 -> busy=1 from t+1.
  - Continuous: cont=1, en=1 -> RUN, start ignored.
- RUN:
  - Counter increments each en cycle. At count H-1 the counter wraps to 0, SCK toggles and BaudRate=1 in the same registered cycle.
  - Edges are numbered from 1. Odd edges assert lead_edge; even edges assert trail_edge.
  - First edge occurs H cycles after busy rises.
- Burst end: on edge 2*num_bits, SCK returns to latched CPOL, trail_edge=1, done=1 and busy=0 in that same cycle. State -> IDLE (or GUARD if enabled).
- Continuous mode: no done. When cont falls, the block runs to the next trailing edge, then goes to IDLE with no done pulse.
- start while busy: ignored.
- start with num_bits=0: no edges, busy stays 0, done=1 on cycle t+1.
- en=0: counters, SCK and state hold; strobes forced 0. Resuming continues exactly where it paused.
- clr=1 (synchronous, priority over en/start): state=IDLE, counters 0, SCK=CPOL, strobes/busy/done=0 next cycle.
- clr and start in the same cycle: clr wins.
- Reset mid-burst: immediate return to reset values; no done.
- Strobes are mutually exclusive and only ever 1 cycle wide, even at H=1.

Optional Feature:
- Macro BRG_GUARD_EN.
- Defined: after the last trailing edge the FSM enters GUARD for H cycles. busy stays 1 and SCK=CPOL; done=1 and busy=0 on the cycle the guard expires. Provides minimum inter-transfer idle time. Continuous-mode stop also passes through GUARD, still without done.
- Undefined: no GUARD state; done coincides with the last edge.

Test Plan:
- Reset/idle: rst=0 mid-run with SPPR=2, SPR=1 -> all outputs 0 immediately. After release with CPOL=1, SCK=1 in IDLE.
- Divisor sweep: cont=1, en=1, CPOL=0. SPPR=0/SPR=0 -> SCK toggles every cycle. SPPR=2/SPR=1 -> H=6, period 12, BaudRate every 6 cycles. SPPR=7/SPR=7 -> H=1024.
- Burst: SPPR=0, SPR=0, num_bits=8, start at t -> busy rises t+1; 16 edges at t+2..t+17 alternating lead/trail; done=1 and busy=0 at t+17; SCK=CPOL after. With BRG_GUARD_EN: done at t+18.
- Pause/config: en=0 for 5 cycles mid-burst -> edge times shift by exactly 5. SPR changed mid-burst -> H unchanged. start while busy -> ignored.
- Boundaries: num_bits=0 -> done at t+1, no SCK edge. clr and start in the same cycle -> stays IDLE. clr mid-burst -> IDLE next cycle, no done.
- Continuous stop: cont falls after a lead edge -> exactly one more trail edge, then IDLE, busy=0, no done.
